switch_bounce_emulator: RTL

//  Transmit side of the push-button link: turns a clean level request into a

---
 rtl/switch_bounce_emulator.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/switch_bounce_emulator.sv
// Bounce emulator: turns a clean level request into a mechanically realistic
// burst of toggles on o_noisy, with fixed or LFSR-randomised glitch count/gap.
module switch_bounce_emulator #(
  parameter int          RANDOM     = 0,
  parameter int          N_GLITCH   = 2,
  parameter int          GAP        = 3,
  parameter int          MIN_GAP    = 2,
  parameter int          GAP_W      = 4,
  parameter int          GLITCH_W   = 3,
  parameter int          SETTLE_CYC = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clean,
  output logic o_noisy,
  output logic o_busy,
  output logic o_done
);

  localparam int RGAP_MAX = MIN_GAP + (1 << GAP_W) - 1;
  localparam int GAP_MAX  = (GAP > RGAP_MAX) ? GAP : RGAP_MAX;
  localparam int TOG_R    = 2 * (1 << GLITCH_W);
  localparam int TOG_MAX  = (TOG_R > 2 * N_GLITCH) ? TOG_R : 2 * N_GLITCH;
  localparam int MAX_A    = (GAP_MAX > SETTLE_CYC) ? GAP_MAX : SETTLE_CYC;
  localparam int CNT_MAX  = (MAX_A > TOG_MAX) ? MAX_A : TOG_MAX;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BOUNCE = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_noisy;
  logic             r_busy;
  logic             r_done;
  logic             r_settled;
  logic             r_target;
  logic [15:0]      r_lfsr;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_tog_left;
  logic [CNT_W-1:0] r_settle_cnt;

  logic             w_noisy_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_settled_nxt;
  logic             w_target_nxt;
  logic [CNT_W-1:0] w_gap_nxt;
  logic [CNT_W-1:0] w_tog_nxt;
  logic [CNT_W-1:0] w_settle_nxt;

  logic             w_start;
  logic             w_gap_exp;
  logic             w_last_tog;
  logic             w_settle_exp;
  logic [CNT_W-1:0] w_gap_load;
  logic [CNT_W-1:0] w_tog_load;

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [CNT_W-1:0] gap_from(input logic [15:0] v);
    logic [CNT_W-1:0] g;
    if (RANDOM != 0) begin
      g = CNT_W'(MIN_GAP) + CNT_W'(v[GAP_W-1:0]);
    end else begin
      g = CNT_W'(GAP);
    end
    return g;
  endfunction

  function automatic logic [CNT_W-1:0] toggles_from(input logic [15:0] v);
    logic [CNT_W-1:0] t;
    if (RANDOM != 0) begin
      t = CNT_W'(v[15 -: GLITCH_W]) << 1;
    end else begin
      t = CNT_W'(N_GLITCH) << 1;
    end
    return t;
  endfunction

  assign w_start      = i_enable & (i_clean != r_settled);
  assign w_gap_exp    = (r_gap_cnt == CNT_W'(1));
  assign w_last_tog   = (r_tog_left == CNT_W'(1));
  assign w_settle_exp = (r_settle_cnt == CNT_W'(1));
  assign w_gap_load   = gap_from(r_lfsr);
  assign w_tog_load   = toggles_from(r_lfsr);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_tog_load == CNT_W'(0)) begin
            w_state_nxt = S_SETTLE;
          end else begin
            w_state_nxt = S_BOUNCE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BOUNCE: begin
        if (w_gap_exp && w_last_tog) begin
          w_state_nxt = S_SETTLE;
        end else begin
          w_state_nxt = S_BOUNCE;
        end
      end
      S_SETTLE: begin
        if (w_settle_exp) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_SETTLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Settle counter is loaded at burst start and only runs once SETTLE is entered
  always_comb begin
    w_noisy_nxt   = r_noisy;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_settled_nxt = r_settled;
    w_target_nxt  = r_target;
    w_gap_nxt     = r_gap_cnt;
    w_tog_nxt     = r_tog_left;
    w_settle_nxt  = r_settle_cnt;
    case (r_state)
      S_IDLE: begin
        if (!i_enable) begin
          w_noisy_nxt   = i_clean;
          w_settled_nxt = i_clean;
          w_busy_nxt    = 1'b0;
        end else if (i_clean != r_settled) begin
          w_target_nxt = i_clean;
          w_noisy_nxt  = i_clean;
          w_busy_nxt   = 1'b1;
          w_tog_nxt    = w_tog_load;
          w_gap_nxt    = w_gap_load;
          w_settle_nxt = CNT_W'(SETTLE_CYC);
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_BOUNCE: begin
        if (w_gap_exp) begin
          w_noisy_nxt = ~r_noisy;
          w_tog_nxt   = r_tog_left - CNT_W'(1);
          w_gap_nxt   = w_gap_load;
        end else begin
          w_gap_nxt = r_gap_cnt - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (w_settle_exp) begin
          w_settled_nxt = r_target;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
        end else begin
          w_settle_nxt = r_settle_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_noisy      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_settled    <= 1'b0;
      r_target     <= 1'b0;
      r_lfsr       <= LFSR_SEED;
      r_gap_cnt    <= CNT_W'(0);
      r_tog_left   <= CNT_W'(0);
      r_settle_cnt <= CNT_W'(0);
    end else begin
      r_noisy      <= w_noisy_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_settled    <= w_settled_nxt;
      r_target     <= w_target_nxt;
      r_lfsr       <= lfsr_next(r_lfsr);
      r_gap_cnt    <= w_gap_nxt;
      r_tog_left   <= w_tog_nxt;
      r_settle_cnt <= w_settle_nxt;
    end
  end

  assign o_noisy = r_noisy;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule
